// File: rtl/dcfeb_wr_pkg.sv
// Shared definitions for the sample FIFO write controller:
// state encoding, word-select codes, size limits, clamp helper.
package dcfeb_wr_pkg;

  localparam int NSAMP_W = 7;
  localparam int EVT_W   = 12;
  localparam int QCNT_W  = 3;

  localparam logic [NSAMP_W-1:0] MAX_NSAMP  = 7'd96;
  localparam logic [QCNT_W-1:0]  QDEPTH_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_TRL  = 2'd3
  } wr_state_t;

  localparam logic [1:0] WSEL_DATA = 2'b00;
  localparam logic [1:0] WSEL_HDR  = 2'b01;
  localparam logic [1:0] WSEL_TRL  = 2'b10;

  function automatic logic [NSAMP_W-1:0] clamp_nsamp(
    input logic [NSAMP_W-1:0] n
  );
    return (n > MAX_NSAMP) ? MAX_NSAMP : n;
  endfunction

  function automatic logic [1:0] wsel_of(input wr_state_t s);
    logic [1:0] w;
    w = WSEL_DATA;
    unique case (s)
      ST_HDR:  w = WSEL_HDR;
      ST_TRL:  w = WSEL_TRL;
      default: w = WSEL_DATA;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trig_pend_cnt.sv
// Pending-trigger counter: triggers waiting behind the current event.
// Ports: CLK, RST (async high), CLR, INC, DEC, CNT (0..7), FULL.
module trig_pend_cnt
  import dcfeb_wr_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              INC,
  input  logic              DEC,
  output logic [QCNT_W-1:0] CNT,
  output logic              FULL
);

  assign FULL = (CNT == QDEPTH_MAX);

  // Simultaneous INC and DEC cancel out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CNT <= '0;
    end else if (CLR) begin
      CNT <= '0;
    end else if (INC && !DEC && !FULL) begin
      CNT <= CNT + 3'd1;
    end else if (DEC && !INC && CNT != '0) begin
      CNT <= CNT - 3'd1;
    end
  end

endmodule

// File: rtl/sample_fifo_wr_ctrl.sv
// Sample FIFO write controller: per trigger writes header, NSAMP data
// words (clamped to 96) and trailer, with registered WREN/WSEL.
// Ports: CLK, RST (async high), FIFO_RDY, FIFO_RST, TRIG, NSAMP, PAF
// in; WREN, WSEL, EVT_NUM, BUSY, MISSED, QDEPTH out.
// Build option: define TRIG_QUEUE_EN to add the 7-deep trigger queue;
// without it QDEPTH is 0 and triggers during an event are lost.
module sample_fifo_wr_ctrl
  import dcfeb_wr_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               FIFO_RDY,
  input  logic               FIFO_RST,
  input  logic               TRIG,
  input  logic [NSAMP_W-1:0] NSAMP,
  input  logic               PAF,
  output logic               WREN,
  output logic [1:0]         WSEL,
  output logic [EVT_W-1:0]   EVT_NUM,
  output logic               BUSY,
  output logic               MISSED,
  output logic [QCNT_W-1:0]  QDEPTH
);

  wr_state_t          state;
  wr_state_t          nxt;
  logic [NSAMP_W-1:0] cnt;
  logic [NSAMP_W-1:0] n_clamp;
  logic               fault;
  logic               acc_ok;
  logic               room;
  logic               acc;
  logic               q_pend;
  logic               abort;

  assign fault   = ~FIFO_RDY | FIFO_RST;
  assign acc_ok  = TRIG & ~fault & ~PAF;
  assign n_clamp = clamp_nsamp(NSAMP);
  assign abort   = fault & (state != ST_IDLE);
  assign acc     = acc_ok & room;

`ifdef TRIG_QUEUE_EN
  logic q_full;
  logic q_inc;
  logic q_dec;
  logic start;

  assign start  = (nxt == ST_HDR);
  assign room   = ~q_full;
  assign q_pend = (QDEPTH != '0);
  // A queued trigger is consumed on every Hdr entry; a new trigger
  // is queued unless it is itself the one starting the event.
  assign q_dec  = start & q_pend;
  assign q_inc  = acc & ~(start & ~q_pend);

  trig_pend_cnt u_pend (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (abort),
    .INC  (q_inc),
    .DEC  (q_dec),
    .CNT  (QDEPTH),
    .FULL (q_full)
  );
`else
  // Without a queue a trigger is only taken when an event can start.
  assign room   = (state == ST_IDLE) | (state == ST_TRL);
  assign q_pend = 1'b0;
  assign QDEPTH = '0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (acc | (q_pend & ~fault)) nxt = ST_HDR;
      end
      ST_HDR: begin
        if (fault)               nxt = ST_IDLE;
        else if (n_clamp != '0)  nxt = ST_DATA;
        else                     nxt = ST_TRL;
      end
      ST_DATA: begin
        if (fault)               nxt = ST_IDLE;
        else if (cnt == 7'd1)    nxt = ST_TRL;
      end
      ST_TRL: begin
        if (fault)               nxt = ST_IDLE;
        else if (acc | q_pend)   nxt = ST_HDR;
        else                     nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      WREN    <= 1'b0;
      WSEL    <= WSEL_DATA;
      cnt     <= '0;
      EVT_NUM <= '0;
      MISSED  <= 1'b0;
    end else begin
      state <= nxt;
      WREN  <= (nxt != ST_IDLE);
      WSEL  <= wsel_of(nxt);
      if (state == ST_HDR)      cnt <= n_clamp;
      else if (nxt == ST_DATA)  cnt <= cnt - 7'd1;
      else                      cnt <= '0;
      // Aborted trailers do not advance the event number.
      if (state == ST_TRL && !fault) EVT_NUM <= EVT_NUM + 12'd1;
      if ((TRIG & ~acc) | abort)     MISSED  <= 1'b1;
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_sample_fifo_wr_ctrl.sv
// Scoreboard bench for sample_fifo_wr_ctrl: a word-level event model
// predicts every FIFO write and per-cycle status.
module tb_sample_fifo_wr_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_RDY = 1'b0;
  logic        FIFO_RST = 1'b0;
  logic        TRIG = 1'b0;
  logic [6:0]  NSAMP = 7'd0;
  logic        PAF = 1'b0;
  logic        WREN;
  logic [1:0]  WSEL;
  logic [11:0] EVT_NUM;
  logic        BUSY;
  logic        MISSED;
  logic [2:0]  QDEPTH;

  sample_fifo_wr_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .FIFO_RDY (FIFO_RDY),
    .FIFO_RST (FIFO_RST),
    .TRIG     (TRIG),
    .NSAMP    (NSAMP),
    .PAF      (PAF),
    .WREN     (WREN),
    .WSEL     (WSEL),
    .EVT_NUM  (EVT_NUM),
    .BUSY     (BUSY),
    .MISSED   (MISSED),
    .QDEPTH   (QDEPTH)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

`ifdef TRIG_QUEUE_EN
  localparam bit QON = 1'b1;
`else
  localparam bit QON = 1'b0;
`endif

  typedef struct {
    int         c;
    logic [1:0] ws;
    int         ev;
  } wexp_t;

  typedef struct {
    int c;
    int busy;
    int qd;
    int ms;
  } sexp_t;

  wexp_t wq[$];
  sexp_t sq[$];
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;

  // Model: words left in current event, its length, pending count.
  int m_left, m_len, m_pend, m_evt;
  bit m_missed;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit trig, input bit rdy,
                      input bit frst, input bit paf);
    bit    fault, room, acc;
    int    n;
    wexp_t w;
    sexp_t s;
    @(negedge CLK);
    TRIG = trig; FIFO_RDY = rdy; FIFO_RST = frst; PAF = paf;
    fault = !rdy || frst;
    room  = QON ? (m_pend < 7) : (m_left <= 1);
    acc   = trig && !fault && !paf && room;
    if (trig && !acc) m_missed = 1'b1;
    if (m_left > 0 && fault) begin
      m_left = 0; m_pend = 0; m_missed = 1'b1;
    end else begin
      if (m_left == 1) m_evt = (m_evt + 1) % 4096;
      if (m_left > 0) m_left--;
      if (m_left == 0) begin
        if (acc || m_pend > 0) begin
          if (m_pend > 0) m_pend = m_pend - 1 + (acc ? 1 : 0);
          n = (NSAMP > 96) ? 96 : int'(NSAMP);
          m_len = n + 2;
          m_left = m_len;
        end
      end else if (acc) begin
        m_pend++;
      end
    end
    s.c = cyc + 1; s.busy = (m_left > 0); s.qd = m_pend;
    s.ms = m_missed;
    sq.push_back(s);
    if (m_left > 0) begin
      w.c = cyc + 1; w.ev = m_evt;
      if (m_left == m_len)  w.ws = 2'b01;
      else if (m_left == 1) w.ws = 2'b10;
      else                  w.ws = 2'b00;
      wq.push_back(w);
    end
  endtask

  // Monitor: pops expectations as the DUT presents writes/status.
  initial begin
    wexp_t w;
    sexp_t s;
    forever begin
      @(posedge CLK);
      #1;
      if (mon_en) begin
        if (sq.size() > 0 && sq[0].c <= cyc) begin
          s = sq.pop_front();
          chk("st_cycle", s.c, cyc);
          chk("busy", int'(BUSY), s.busy);
          chk("qdepth", int'(QDEPTH), s.qd);
          chk("missed", int'(MISSED), s.ms);
        end
        if (WREN) begin
          if (wq.size() == 0) begin
            chk("unexpected_wren", 1, 0);
          end else begin
            w = wq.pop_front();
            chk("wr_cycle", cyc, w.c);
            chk("wsel", int'(WSEL), int'(w.ws));
            chk("evt_num", int'(EVT_NUM), w.ev);
          end
        end else if (wq.size() > 0 && wq[0].c <= cyc) begin
          w = wq.pop_front();
          chk("missing_wren", 0, 1);
        end
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    RST = 1'b1; TRIG = 1'b0; FIFO_RDY = 1'b1;
    FIFO_RST = 1'b0; PAF = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    m_left = 0; m_len = 0; m_pend = 0; m_evt = 0; m_missed = 1'b0;
    wq.delete();
    sq.delete();
    chk("rst_wren", int'(WREN), 0);
    chk("rst_wsel", int'(WSEL), 0);
    chk("rst_evt", int'(EVT_NUM), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_missed", int'(MISSED), 0);
    chk("rst_qdepth", int'(QDEPTH), 0);
    RST = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    while ((m_left > 0 || m_pend > 0) && k < 2000) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      k++;
    end
    if (k >= 2000) chk("drain_timeout", k, 0);
  endtask

  task automatic settle();
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wq_empty", wq.size(), 0);
  endtask

  task automatic peek();
    @(posedge CLK);
    #1;
  endtask

  int ev0;
  bit r_trig, r_rdy, r_frst, r_paf;

  initial begin
    do_reset();

    // Single event, 8 data words.
    NSAMP = 7'd8;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    peek();
    chk("evt_after_one", int'(EVT_NUM), 1);
    settle();

    // Empty event, then clamped event.
    NSAMP = 7'd0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    settle();
    NSAMP = 7'd127;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    peek();
    chk("evt_after_three", int'(EVT_NUM), 3);
    settle();

    // Triggers arriving during an event.
    NSAMP = 7'd8;
    ev0 = int'(EVT_NUM);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef TRIG_QUEUE_EN
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 6) begin
        peek();
        chk("qdepth_full", int'(QDEPTH), 7);
      end
    end
    drain();
    peek();
    chk("burst_missed", int'(MISSED), 1);
    chk("burst_events", int'(EVT_NUM) - ev0, 8);
`else
    step(1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    peek();
    chk("noq_missed", int'(MISSED), 1);
    chk("noq_events", int'(EVT_NUM) - ev0, 1);
`endif
    settle();

    // FIFO reset in the 4th data cycle.
    do_reset();
    NSAMP = 7'd8;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    peek();
    chk("abort_wren", int'(WREN), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_qdepth", int'(QDEPTH), 0);
    chk("abort_missed", int'(MISSED), 1);
    chk("abort_evt", int'(EVT_NUM), 0);
    settle();

    // Rejected triggers.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    peek();
    chk("nordy_missed", int'(MISSED), 1);
    chk("nordy_wren", int'(WREN), 0);
    settle();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    peek();
    chk("paf_missed", int'(MISSED), 1);
    chk("paf_wren", int'(WREN), 0);
    settle();

    // Event number wrap.
    do_reset();
    NSAMP = 7'd0;
    for (int i = 0; i < 4095; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      drain();
    end
    peek();
    chk("evt_4095", int'(EVT_NUM), 4095);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    peek();
    chk("evt_wrap", int'(EVT_NUM), 0);
    settle();

    // Randomized traffic.
    do_reset();
    NSAMP = 7'd3;
    for (int i = 0; i < 3000; i++) begin
      if (m_left == 0 && m_pend == 0 && $urandom_range(0, 9) == 0) begin
        NSAMP = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(90, 127))
                                           : 7'($urandom_range(0, 12));
        step(1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        r_trig = ($urandom_range(0, 3) == 0);
        r_rdy  = ($urandom_range(0, 99) != 0);
        r_frst = ($urandom_range(0, 199) == 0);
        r_paf  = ($urandom_range(0, 19) == 0);
        step(r_trig, r_rdy, r_frst, r_paf);
      end
    end
    drain();
    settle();

    // Asynchronous reset mid-event.
    do_reset();
    NSAMP = 7'd20;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    mon_en = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("async_wren", int'(WREN), 0);
    chk("async_busy", int'(BUSY), 0);
    chk("async_wsel", int'(WSEL), 0);
    do_reset();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_fifo_wr_ctrl.md
SAMPLE_FIFO_WR_CTRL -- requirements
Module: sample_fifo_wr_ctrl

Interface
REQ-001 The module SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- FIFO_RDY  in  1  DONE from the FIFO reset sequencer; 1 = sample FIFOs initialised and writable.
- FIFO_RST  in  1  FIFO reset in progress, from the same sequencer.
- TRIG  in  1  one-cycle event trigger (L1A).
- NSAMP  in  7  data words per event, 0..96.
- PAF  in  1  FIFO programmable-almost-full.
- WREN  out  1  FIFO write enable, registered.
- WSEL  out  2  word mux select, registered: 00 data, 01 header, 10 trailer.
- EVT_NUM  out  12  event number written in the header/trailer.
- BUSY  out  1  high while an event is being written.
- MISSED  out  1  sticky: at least one trigger lost.
- QDEPTH  out  3  triggers pending behind the current event.

Function
REQ-002 Trigger SHALL be accepted iff TRIG=1, FIFO_RDY=1, FIFO_RST=0, PAF=0 and queue not full; any other TRIG=1 cycle SHALL set MISSED.
REQ-003 FSM states SHALL be Idle, Hdr, Data, Trl; outputs SHALL be registered and decoded from next state.
REQ-004 Idle -> Hdr on an accepted trigger or QDEPTH>0; TRIG accepted in cycle n SHALL give WREN=1, WSEL=01 in cycle n+1.
REQ-005 Hdr SHALL last 1 cycle and latch NSAMP; values above 96 SHALL be clamped to 96; Hdr -> Data if latched count >0, else -> Trl.
REQ-006 Data SHALL assert WREN=1, WSEL=00 for exactly the latched count of cycles, then -> Trl.
REQ-007 Trl SHALL assert WREN=1, WSEL=10 for 1 cycle and increment EVT_NUM on exit, wrapping 4095 -> 0.
REQ-008 Trl SHALL go to Hdr directly when QDEPTH>0 or a trigger is accepted that cycle, else to Idle; an event is exactly NSAMP+2 consecutive WREN cycles.
REQ-009 QDEPTH SHALL increment on a trigger accepted while not starting an event, decrement on each Hdr entry from the queue, and stay unchanged when both occur in one cycle; it saturates at 7.
REQ-010 FIFO_RDY=0 or FIFO_RST=1 in any non-Idle state SHALL abort to Idle the next cycle with WREN=0; QDEPTH SHALL clear and MISSED SHALL set; EVT_NUM SHALL not increment.
REQ-011 BUSY SHALL be 1 exactly when the registered state is not Idle.
REQ-012 MISSED SHALL clear only on RST.

Reset
REQ-013 On RST: state Idle, WREN=0, WSEL=00, EVT_NUM=0, BUSY=0, MISSED=0, QDEPTH=0, sample counter 0.
REQ-014 RST asserted mid-event SHALL drop WREN asynchronously with no trailer written.

Configuration
REQ-015 Macro TRIG_QUEUE_EN compiled in: the 7-deep pending-trigger queue of REQ-009 is present.
REQ-016 Macro TRIG_QUEUE_EN compiled out: no queue; QDEPTH is tied to 0; a trigger arriving while BUSY=1 (except during Trl -> Hdr) sets MISSED.

Structure
REQ-017 Shared package dcfeb_wr_pkg SHALL hold the state encoding, WSEL codes, MAX_NSAMP=96, EVT_NUM width 12 and queue depth 7.
REQ-018 The pending-trigger counter SHALL be a sub-module trig_pend_cnt, instantiated only under TRIG_QUEUE_EN.

Verification
REQ-019 FIFO_RDY=1, NSAMP=8, single TRIG at cycle 0 -> WREN cycles 1..10; WSEL 01, eight 00s, then 10; EVT_NUM 0 -> 1 after cycle 10.
REQ-020 NSAMP=0, TRIG -> WREN cycles 1..2 (header, trailer only); NSAMP=127 -> 96 data words.
REQ-021 Queue on: 9 TRIGs in the first data cycle stream -> QDEPTH reaches 7, MISSED=1, 8 back-to-back events with no idle gap.
REQ-022 FIFO_RST pulse in Data cycle 4 -> WREN=0 next cycle, state Idle, QDEPTH=0, MISSED=1, EVT_NUM unchanged.
REQ-023 TRIG with FIFO_RDY=0 or PAF=1 -> no write, MISSED=1; EVT_NUM preset to 4095 plus one event -> EVT_NUM=0.
REQ-024 Queue off: second TRIG during Data -> MISSED=1, only one event written.
